// File: rtl/shift_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl_pkg
//   Shared definitions for the multi-cycle shifter controller.
//   Holds the shift-mode encodings (as seen on the mode input) and the
//   controller state encoding.
// ---------------------------------------------------------------------------
package shift_seq_ctrl_pkg;

    // Shift mode encodings. The fourth code (2'b11) is reserved and is
    // treated exactly like SH_LOG by the datapath.
    localparam logic [1:0] SH_LOG = 2'b00;
    localparam logic [1:0] SH_ARI = 2'b01;
    localparam logic [1:0] SH_ROT = 2'b10;

    // Direction encoding shared with the shift1 stage.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl_shift1.sv
// ---------------------------------------------------------------------------
// shift1
//   Combinational one-bit shifter with zero fill. Fill-bit patching for
//   arithmetic and rotate modes is left to the instantiating block.
//
//   Ports
//     a    in  W   operand
//     dir  in  1   0 = left, 1 = right
//     y    out W   a shifted by one position, vacated bit = 0
// ---------------------------------------------------------------------------
module shift1 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic         dir,
    output logic [W-1:0] y
);

    always_comb begin
        if (dir) begin
            y = {1'b0, a[W-1:1]};
        end else begin
            y = {a[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
//   Multi-cycle shifter. On an accepted start it latches the operand,
//   direction and mode, then applies one 1-bit step per clock until the
//   effective count is exhausted, and presents the result with a one-cycle
//   done pulse. Sits between the ALU opcode decoder and the result mux.
//
//   Ports
//     clk    in  1    clock, all state changes on posedge
//     rst    in  1    synchronous active-high reset
//     start  in  1    request, accepted when busy=0 (IDLE or DONE)
//     dir    in  1    0 = left, 1 = right
//     mode   in  2    00 logical, 01 arithmetic, 10 rotate, 11 = logical
//     amt    in  AW   shift amount
//     a      in  W    operand
//     y      out W    result, valid with done, held until the next result
//     busy   out 1    high while shifting
//     done   out 1    one-cycle pulse when y is updated
// ---------------------------------------------------------------------------
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int W  = 8,
    parameter int AW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dir,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] amt,
    input  logic [W-1:0]  a,
    output logic [W-1:0]  y,
    output logic          busy,
    output logic          done
);

    state_t        state, state_nxt;
    logic [W-1:0]  work;
    logic [AW-1:0] cnt;
    logic          dir_q;
    logic [1:0]    mode_q;

    logic          accept;
    logic [AW-1:0] n_eff;
    logic [W-1:0]  sh_out;
    logic [W-1:0]  step_out;
    logic          last_step;

    // A new request is taken whenever we are not mid-shift, which lets a
    // start coincide with the done cycle without an idle bubble.
    assign accept    = start && (state != ST_SHIFT);
    assign last_step = (cnt == AW'(1));

    // Effective step count. Rotations wrap modulo W; shifts saturate at W
    // since anything beyond W steps yields the same fully-filled value.
    // W < 2^AW always holds, so W fits in the counter.
    always_comb begin
        n_eff = amt;
        if (mode == SH_ROT) begin
            n_eff = AW'(amt % W);
        end else if (amt > AW'(W)) begin
            n_eff = AW'(W);
        end
    end

    // -----------------------------------------------------------------------
    // Data step: zero-fill shifter plus local fill-bit patching
    // -----------------------------------------------------------------------
    shift1 #(.W(W)) u_shift1 (
        .a   (work),
        .dir (dir_q),
        .y   (sh_out)
    );

    always_comb begin
        step_out = sh_out;
        if (mode_q == SH_ROT) begin
            // Bit shifted out re-enters at the vacated end.
            if (dir_q == DIR_RIGHT) begin
                step_out[W-1] = work[0];
            end else begin
                step_out[0] = work[W-1];
            end
        end else if ((mode_q == SH_ARI) && (dir_q == DIR_RIGHT)) begin
            // Sign extension; arithmetic left is identical to logical left.
            step_out[W-1] = work[W-1];
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_nxt = (n_eff == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_step) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: work register, down-counter, latched controls, result
    // -----------------------------------------------------------------------
    // y is written only on the edge that enters DONE, so it keeps the prior
    // result throughout a shift and matches work during the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            work   <= '0;
            cnt    <= '0;
            dir_q  <= 1'b0;
            mode_q <= SH_LOG;
            y      <= '0;
        end else if (accept) begin
            work   <= a;
            cnt    <= n_eff;
            dir_q  <= dir;
            mode_q <= mode;
            if (n_eff == '0) begin
                y <= a;
            end
        end else if (state == ST_SHIFT) begin
            work <= step_out;
            cnt  <= cnt - AW'(1);
            if (last_step) begin
                y <= step_out;
            end
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl
//   Directed bench for shift_seq_ctrl (W=8). Each accepted request pushes
//   its expected result and expected done cycle into a scoreboard; a monitor
//   pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_shift_seq_ctrl;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          dir;
    logic [1:0]    mode;
    logic [AW-1:0] amt;
    logic [W-1:0]  a;
    logic [W-1:0]  y;
    logic          busy;
    logic          done;

    shift_seq_ctrl #(.W(W), .AW(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .dir   (dir),
        .mode  (mode),
        .amt   (amt),
        .a     (a),
        .y     (y),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        int           due;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   tests    = 0;
    int   fails    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Effective step count, written from the behavioural definition.
    function automatic int n_of(input logic [1:0] m, input logic [AW-1:0] am);
        int v;
        v = int'(am);
        if (m == 2'b10) return v % W;
        return (v > W) ? W : v;
    endfunction

    // Reference result built from whole-word operators, not single steps.
    function automatic logic [W-1:0] model(input logic d, input logic [1:0] m,
                                           input logic [AW-1:0] am, input logic [W-1:0] av);
        int                  n;
        logic [2*W-1:0]      t;
        logic signed [W-1:0] s;
        n = n_of(m, am);
        t = {av, av};
        s = av;
        if (m == 2'b10) begin
            if (d) begin
                t = t >> n;
                return t[W-1:0];
            end
            t = t << n;
            return t[2*W-1:W];
        end
        if (m == 2'b01 && d) return W'(s >>> n);
        if (d) return av >> n;
        return av << n;
    endfunction

    // Monitor: counts busy cycles and checks every done against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                tests++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_done: y=%b with empty scoreboard at cycle %0d", y, cyc);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    tests++;
                    assert (y === e.y) else begin
                        fails++;
                        $error("FAIL %s_y: got %b expected %b", e.tag, y, e.y);
                    end
                    tests++;
                    assert (cyc === e.due) else begin
                        fails++;
                        $error("FAIL %s_latency: done at cycle %0d expected %0d", e.tag, cyc, e.due);
                    end
                end
            end
        end
    end

    // Drive a request that must be accepted; call at a negedge.
    task automatic issue(input logic d, input logic [1:0] m, input logic [AW-1:0] am,
                         input logic [W-1:0] av, input string tag);
        exp_t e;
        start = 1'b1; dir = d; mode = m; amt = am; a = av;
        @(posedge clk); #1;
        start = 1'b0;
        e.y   = model(d, m, am, av);
        e.due = cyc + n_of(m, am);
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Wait (bounded) until the scoreboard drains; returns at a negedge.
    task automatic wait_done(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL %s_timeout: %0d results outstanding, expected 0", tag, sb.size());
        end
    endtask

    task automatic check_busy(input int b0, input int exp_n, input string tag);
        tests++;
        assert (busy_cnt - b0 === exp_n) else begin
            fails++;
            $error("FAIL %s_busy: busy high %0d cycles expected %0d", tag, busy_cnt - b0, exp_n);
        end
    endtask

    task automatic check_sig(input logic [W-1:0] got, input logic [W-1:0] exp, input string tag);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        int b0;
        rst = 1'b1; start = 1'b0; dir = 1'b0; mode = 2'b00; amt = '0; a = '0;
        repeat (3) @(posedge clk);
        #1;
        check_sig(y, 8'h00, "reset_y");
        check_sig(W'(busy), W'(0), "reset_busy");
        check_sig(W'(done), W'(0), "reset_done");
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // 1. logical left 3
        b0 = busy_cnt;
        issue(1'b0, 2'b00, 4'd3, 8'b10101010, "log_left3");
        wait_done("log_left3");
        check_busy(b0, 3, "log_left3");
        check_sig(y, 8'b01010000, "log_left3_const");

        // 2. arith right vs logical right
        issue(1'b1, 2'b01, 4'd2, 8'b10110011, "ari_right2");
        wait_done("ari_right2");
        check_sig(y, 8'b11101100, "ari_right2_const");
        issue(1'b1, 2'b00, 4'd2, 8'b10110011, "log_right2");
        wait_done("log_right2");
        issue(1'b0, 2'b01, 4'd2, 8'b10110011, "ari_left2");
        wait_done("ari_left2");

        // 3. rotates, including wrap of amt=9
        issue(1'b1, 2'b10, 4'd3, 8'b00110011, "rot_right3");
        wait_done("rot_right3");
        check_sig(y, 8'b01100110, "rot_right3_const");
        b0 = busy_cnt;
        issue(1'b0, 2'b10, 4'd9, 8'b00110011, "rot_left9");
        wait_done("rot_left9");
        check_busy(b0, 1, "rot_left9");

        // 4. amt=0 in every mode, and saturation at W
        for (int m = 0; m < 4; m++) begin
            b0 = busy_cnt;
            issue(m[0], 2'(m), 4'd0, 8'b11110000, $sformatf("amt0_mode%0d", m));
            wait_done("amt0");
            check_busy(b0, 0, "amt0");
        end
        b0 = busy_cnt;
        issue(1'b0, 2'b00, 4'd12, 8'b11111111, "log_left12");
        wait_done("log_left12");
        check_busy(b0, 8, "log_left12");
        issue(1'b1, 2'b11, 4'd15, 8'b11000011, "reserved_right15");
        wait_done("reserved_right15");

        // 5a. start while busy is ignored
        issue(1'b0, 2'b00, 4'd3, 8'b10101010, "busy_ignore");
        @(negedge clk);
        start = 1'b1; dir = 1'b1; mode = 2'b10; amt = 4'd0; a = 8'b00000001;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_ignore");
        repeat (3) @(negedge clk);
        check_sig(y, 8'b01010000, "busy_ignore_hold");

        // 5b. start coincident with done
        issue(1'b1, 2'b00, 4'd2, 8'b11110000, "b2b_first");
        for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
        check_sig(W'(done), W'(1), "b2b_done_seen");
        issue(1'b1, 2'b10, 4'd1, 8'b10000001, "b2b_second");
        #1;
        check_sig(W'(busy), W'(1), "b2b_no_gap");
        wait_done("b2b_second");

        // 6. reset mid-shift aborts without a done pulse
        issue(1'b0, 2'b00, 4'd5, 8'b11111111, "aborted");
        @(negedge clk);
        check_sig(W'(busy), W'(1), "abort_busy_before");
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        check_sig(y, 8'h00, "abort_y");
        check_sig(W'(busy), W'(0), "abort_busy");
        check_sig(W'(done), W'(0), "abort_done");
        @(negedge clk); rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(1'b1, 2'b01, 4'd4, 8'b10010110, "after_reset");
        wait_done("after_reset");
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
